// File: rtl/seg7_scan_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_if
// Bundle of display data and drive signals between a host (master) and the
// seven-segment scan driver (slave).
//   bcd_in     [4*DIGITS] packed BCD, digit i at bits [4i+3:4i]
//   load                  capture bcd_in/dp_in/blink_mask into shadow regs
//   dp_in      [DIGITS]   decimal-point request per digit
//   blink_mask [DIGITS]   per-digit blink enable
//   blank_lz              leading-zero blanking enable (live)
//   seg_out    [7]        segments a..g (bit6=a, bit0=g)
//   dp_out                decimal point of the active digit
//   an_out     [DIGITS]   one-hot digit select
//   frame_done            one-cycle pulse per completed scan frame
// ---------------------------------------------------------------------------
interface seg7_scan_if #(
    parameter int DIGITS = 4
) ();
    logic [4*DIGITS-1:0] bcd_in;
    logic                load;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blink_mask;
    logic                blank_lz;
    logic [6:0]          seg_out;
    logic                dp_out;
    logic [DIGITS-1:0]   an_out;
    logic                frame_done;

    modport master (
        output bcd_in, load, dp_in, blink_mask, blank_lz,
        input  seg_out, dp_out, an_out, frame_done
    );

    modport slave (
        input  bcd_in, load, dp_in, blink_mask, blank_lz,
        output seg_out, dp_out, an_out, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed BCD seven-segment display driver with leading-zero
// blanking, per-digit blinking and decimal points. All outputs registered.
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : seg7_scan_if.slave (data inputs, segment/anode/frame outputs)
// Parameters: DIGITS (2..8), SCAN_DIV (>=2 clk per digit), BLINK_DIV
// (>=1 frames per blink half-period), SEG_ACTIVE_LOW, AN_ACTIVE_LOW.
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int BLINK_DIV      = 64,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    // Inactive output levels; XOR with these applies the polarity.
    localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    bcd_to_seg = 7'b1111110;
            4'd1:    bcd_to_seg = 7'b0110000;
            4'd2:    bcd_to_seg = 7'b1101101;
            4'd3:    bcd_to_seg = 7'b1111001;
            4'd4:    bcd_to_seg = 7'b0110011;
            4'd5:    bcd_to_seg = 7'b1011011;
            4'd6:    bcd_to_seg = 7'b1011111;
            4'd7:    bcd_to_seg = 7'b1110000;
            4'd8:    bcd_to_seg = 7'b1111111;
            4'd9:    bcd_to_seg = 7'b1111011;
            default: bcd_to_seg = 7'b0000000;
        endcase
    endfunction

    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [FRM_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic                phase_q, phase_d;
    logic [4*DIGITS-1:0] sh_bcd_q, sh_bcd_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]   sh_mask_q, sh_mask_d;
    logic [6:0]          seg_out_q, seg_out_d;
    logic                dp_out_q, dp_out_d;
    logic [DIGITS-1:0]   an_out_q, an_out_d;
    logic                frame_done_q, frame_done_d;

    logic                tick, wrap;
    logic [3:0]          cur_bcd;
    logic                cur_dp, cur_blink_en, cur_lz, higher_zero, blink_off;
    logic [DIGITS-1:0]   onehot;
    logic [6:0]          seg_on;
    logic                dp_on;

    // Scan timing, blink phase and shadow capture.
    always_comb begin
        tick        = (presc_q == PRE_W'(SCAN_DIV - 1));
        wrap        = tick && (idx_q == IDX_W'(DIGITS - 1));
        presc_d     = tick ? '0 : presc_q + PRE_W'(1);
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
        if (wrap) begin
            if (frame_cnt_q == FRM_W'(BLINK_DIV - 1)) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FRM_W'(1);
            end
        end
        sh_bcd_d  = bus.load ? bus.bcd_in     : sh_bcd_q;
        sh_dp_d   = bus.load ? bus.dp_in      : sh_dp_q;
        sh_mask_d = bus.load ? bus.blink_mask : sh_mask_q;
    end

    // Output image of the currently selected digit, built from registered
    // index/shadow state so the outputs trail them by exactly one cycle.
    always_comb begin
        cur_bcd      = 4'd0;
        cur_dp       = 1'b0;
        cur_blink_en = 1'b0;
        cur_lz       = 1'b0;
        onehot       = '0;
        // Walk from the most significant digit down: a digit is a leading
        // zero when it and every digit above it are zero.
        higher_zero  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            higher_zero = higher_zero && (sh_bcd_q[4*i +: 4] == 4'd0);
            if (idx_q == IDX_W'(i)) begin
                cur_bcd      = sh_bcd_q[4*i +: 4];
                cur_dp       = sh_dp_q[i];
                cur_blink_en = sh_mask_q[i];
                cur_lz       = bus.blank_lz && higher_zero && (i != 0);
                onehot[i]    = 1'b1;
            end
        end
        blink_off    = cur_blink_en && phase_q;
        seg_on       = (blink_off || cur_lz) ? 7'b0000000 : bcd_to_seg(cur_bcd);
        // A leading-zero digit keeps its decimal point; blinking hides it.
        dp_on        = cur_dp && !blink_off;
        seg_out_d    = seg_on ^ SEG_OFF;
        dp_out_d     = dp_on ^ DP_OFF;
        an_out_d     = onehot ^ AN_OFF;
        frame_done_d = wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            frame_cnt_q  <= '0;
            phase_q      <= 1'b0;
            sh_bcd_q     <= '0;
            sh_dp_q      <= '0;
            sh_mask_q    <= '0;
            seg_out_q    <= SEG_OFF;
            dp_out_q     <= DP_OFF;
            an_out_q     <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            frame_cnt_q  <= frame_cnt_d;
            phase_q      <= phase_d;
            sh_bcd_q     <= sh_bcd_d;
            sh_dp_q      <= sh_dp_d;
            sh_mask_q    <= sh_mask_d;
            seg_out_q    <= seg_out_d;
            dp_out_q     <= dp_out_d;
            an_out_q     <= an_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg_out    = seg_out_q;
    assign bus.dp_out     = dp_out_q;
    assign bus.an_out     = an_out_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
// Two instances of seg7_scan_driver (DIGITS=4, SCAN_DIV=4, BLINK_DIV=2):
// dut_p with active-high segments / active-low anodes, dut_n with the
// opposite polarities, both fed the same stimulus. A time-based reference
// model predicts every output cycle; vector tables and short hand-written
// sequences cover decode, blanking, blinking, load-on-tick and reset.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;
    localparam int D     = 4;
    localparam int S     = 4;
    localparam int B     = 2;
    localparam int FRAME = S * D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd = '0;
    logic        ld  = 1'b0;
    logic [3:0]  dp  = '0;
    logic [3:0]  mask = '0;
    logic        lz  = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: edges since reset release and shadow contents.
    int unsigned t = 0;
    logic [15:0] sh_bcd  = '0;
    logic [3:0]  sh_dp   = '0;
    logic [3:0]  sh_mask = '0;
    int          last_idx = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};

    seg7_scan_if #(.DIGITS(D)) bus_p ();
    seg7_scan_if #(.DIGITS(D)) bus_n ();

    assign bus_p.bcd_in = bcd;  assign bus_p.load = ld;  assign bus_p.dp_in = dp;
    assign bus_p.blink_mask = mask;  assign bus_p.blank_lz = lz;
    assign bus_n.bcd_in = bcd;  assign bus_n.load = ld;  assign bus_n.dp_in = dp;
    assign bus_n.blink_mask = mask;  assign bus_n.blank_lz = lz;

    seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .BLINK_DIV(B),
                       .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1))
        dut_p (.clk(clk), .rst(rst), .bus(bus_p));

    seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .BLINK_DIV(B),
                       .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(0))
        dut_n (.clk(clk), .rst(rst), .bus(bus_n));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (t=%0d): got %h expected %h", name, t, act, exp);
        end
    endtask

    // Active-high prediction {seg[7], dp, an_onehot[4], frame_done} for the
    // output produced by the next clock edge.
    function automatic logic [12:0] model_out();
        int          idx    = int'((t / S) % D);
        int unsigned frames = t / FRAME;
        logic        phase  = ((frames / B) % 2) == 1;
        logic [15:0] upper  = sh_bcd >> (4 * idx);
        logic        lzb    = lz && (idx > 0) && (upper == 16'd0);
        logic        blink  = sh_mask[idx] && phase;
        logic [6:0]  seg    = (blink || lzb) ? 7'd0 : seg_tab[upper[3:0]];
        logic        dpv    = sh_dp[idx] && !blink;
        logic [3:0]  an     = 4'b0001 << idx;
        logic        fd     = ((t + 1) % FRAME) == 0;
        return {seg, dpv, an, fd};
    endfunction

    task automatic step(input logic do_load);
        logic [12:0] m;
        ld = do_load;
        m  = model_out();
        @(posedge clk);
        #1;
        check("cycle_p", {19'd0, bus_p.seg_out, bus_p.dp_out, bus_p.an_out, bus_p.frame_done},
              {19'd0, m[12:5], ~m[4:1], m[0]});
        check("cycle_n", {19'd0, bus_n.seg_out, bus_n.dp_out, bus_n.an_out, bus_n.frame_done},
              {19'd0, ~m[12:5], m[4:1], m[0]});
        last_idx = int'((t / S) % D);
        if (do_load) begin
            sh_bcd  = bcd;
            sh_dp   = dp;
            sh_mask = mask;
        end
        t++;
        ld = 1'b0;
    endtask

    task automatic check_inactive(input string name);
        check({name, "_p"}, {19'd0, bus_p.seg_out, bus_p.dp_out, bus_p.an_out, bus_p.frame_done},
              {19'd0, 7'h00, 1'b0, 4'hF, 1'b0});
        check({name, "_n"}, {19'd0, bus_n.seg_out, bus_n.dp_out, bus_n.an_out, bus_n.frame_done},
              {19'd0, 7'h7F, 1'b1, 4'h0, 1'b0});
    endtask

    // Asynchronous reset applied between edges, held two cycles, released
    // on a falling edge; model restarts from zero.
    task automatic do_reset(input string name);
        #2 rst = 1'b1;
        #1 check_inactive({name, "_async"});
        repeat (2) @(posedge clk);
        #1 check_inactive({name, "_held"});
        @(negedge clk);
        rst     = 1'b0;
        t       = 0;
        sh_bcd  = '0;
        sh_dp   = '0;
        sh_mask = '0;
    endtask

    typedef struct {
        logic [15:0]     bcd;
        logic            lz;
        logic [3:0][6:0] seg;   // expected segments, element 3 = digit 3
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [3:0][6:0] seg_9876;
        vecs[0] = '{16'h1234, 1'b0, {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}};
        vecs[1] = '{16'h0007, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1110000}};
        vecs[2] = '{16'h0000, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}};
        vecs[3] = '{16'h5A9F, 1'b0, {7'b1011011, 7'b0000000, 7'b1111011, 7'b0000000}};
        vecs[4] = '{16'h0000, 1'b0, {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}};
        vecs[5] = '{16'h0508, 1'b1, {7'b0000000, 7'b1011011, 7'b1111110, 7'b1111111}};
        vecs[6] = '{16'h6789, 1'b1, {7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011}};
        seg_9876 = {7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111};

        // Reset state
        repeat (3) @(posedge clk);
        #1 check_inactive("reset");
        @(negedge clk);
        rst = 1'b0;

        // Decode and leading-zero vectors, one full frame each
        for (int v = 0; v < 7; v++) begin
            bcd = vecs[v].bcd; lz = vecs[v].lz; dp = '0; mask = '0;
            step(1'b1);
            for (int c = 0; c < FRAME; c++) begin
                step(1'b0);
                check("tbl_seg_p", {25'd0, bus_p.seg_out}, {25'd0, vecs[v].seg[last_idx]});
                check("tbl_seg_n", {25'd0, bus_n.seg_out}, {25'd0, ~vecs[v].seg[last_idx]});
            end
        end

        // Blink: digit 1 lit two frames, dark two frames; digit 3 steady
        do_reset("rst_blink");
        bcd = 16'h1234; dp = 4'b0010; mask = 4'b0010; lz = 1'b0;
        step(1'b1);
        repeat (4 * FRAME - 1) begin
            step(1'b0);
            if ((t - 1) % FRAME == 5) begin
                if ((t - 1) / FRAME < 2) begin
                    check("blink_lit", {24'd0, bus_p.seg_out, bus_p.dp_out}, {24'd0, 7'b1111001, 1'b1});
                end else begin
                    check("blink_dark", {24'd0, bus_p.seg_out, bus_p.dp_out}, {24'd0, 7'b0000000, 1'b0});
                end
            end
            if ((t - 1) % FRAME == 13) begin
                check("blink_other", {24'd0, bus_p.seg_out, bus_p.dp_out}, {24'd0, 7'b0110000, 1'b0});
            end
        end

        // Load coincident with a tick: new digit shows new data at once
        dp = '0; mask = '0;
        step(1'b1);
        while (t % S != S - 1) step(1'b0);
        bcd = 16'h9876;
        step(1'b1);
        step(1'b0);
        check("load_on_tick", {25'd0, bus_p.seg_out}, {25'd0, seg_9876[last_idx]});

        // Reset during digit 2 dwell; restart at digit 0 with cleared shadow
        bcd = 16'h1234;
        step(1'b1);
        while (t % FRAME != 2 * S + 2) step(1'b0);
        do_reset("rst_mid");
        lz = 1'b0;
        step(1'b0);
        check("post_rst_an", {28'd0, bus_p.an_out}, {28'd0, 4'b1110});
        check("post_rst_seg", {25'd0, bus_p.seg_out}, {25'd0, 7'b1111110});
        repeat (S - 1) begin
            step(1'b0);
            check("post_rst_dwell", {28'd0, bus_p.an_out}, {28'd0, 4'b1110});
        end

        // Randomized stimulus against the reference model
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       bcd = 16'($urandom);
                1:       bcd = 16'($urandom_range(0, 15));
                2:       bcd = 16'($urandom_range(0, 255));
                default: bcd = 16'h0000;
            endcase
            dp   = 4'($urandom);
            mask = 4'($urandom);
            if ($urandom_range(0, 7) == 0) lz = ~lz;
            if (i == 1500) do_reset("rst_rand");
            step($urandom_range(0, 5) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed BCD digits; legal range 2..8.
REQ-002 Parameter SCAN_DIV, default 1000: clk cycles each digit is displayed; minimum 2.
REQ-003 Parameter BLINK_DIV, default 64: completed scan frames per blink half-period; minimum 1.
REQ-004 Parameter SEG_ACTIVE_LOW, default 0: 1 inverts seg_out and dp_out at the output register.
REQ-005 Parameter AN_ACTIVE_LOW, default 1: 1 inverts an_out at the output register.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 bcd_in  input  4*DIGITS  packed BCD; digit i occupies bits [4i+3:4i]; digit 0 is least significant.
REQ-009 load  input  1  when high, capture bcd_in, dp_in and blink_mask into shadow registers at the clock edge.
REQ-010 dp_in  input  DIGITS  decimal-point request per digit.
REQ-011 blink_mask  input  DIGITS  per-digit blink enable.
REQ-012 blank_lz  input  1  leading-zero blanking enable; sampled live, not shadowed.
REQ-013 seg_out  output  7  segments, bit6=a down to bit0=g; registered.
REQ-014 dp_out  output  1  decimal point for the active digit; registered.
REQ-015 an_out  output  DIGITS  one-hot digit select; registered.
REQ-016 frame_done  output  1  one-cycle pulse per completed scan frame; registered.

Function
REQ-017 Prescaler counts 0..SCAN_DIV-1 and wraps; a tick occurs when the count equals SCAN_DIV-1.
REQ-018 On each tick, digit index advances by 1 and wraps from DIGITS-1 to 0.
REQ-019 frame_done is high for exactly the one cycle after the tick that wraps the index from DIGITS-1 to 0.
REQ-020 Blink phase toggles once per BLINK_DIV frame_done pulses; the frame counter wraps at BLINK_DIV-1.
REQ-021 Decode (active-high, before polarity inversion):
- 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
- 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- 10..15 produce blank (0000000).
REQ-022 Leading-zero blank: with blank_lz=1, digit i (i>0) is blanked when shadow digits DIGITS-1 down to i are all 0; digit 0 is never blanked.
REQ-023 Blink blank: digit i is blanked, including its dp, when shadow blink_mask[i]=1 and blink phase=1.
REQ-024 A leading-zero-blanked digit still shows dp when its shadow dp bit is 1 and it is not blink-blanked.
REQ-025 A blanked digit keeps its an_out bit active; only seg_out and dp_out go inactive.
REQ-026 Outputs lag the current index and shadow state by one cycle; no combinational path runs from any input to any output.
REQ-027 A load coincident with a tick makes the newly loaded data and the new index take effect together in the following output cycle.
REQ-028 load does not reset the prescaler, index, frame counter or blink phase.

Reset
REQ-029 While rst=1: prescaler, index, frame counter, blink phase and all shadow registers are 0.
REQ-030 While rst=1: seg_out and dp_out are inactive per polarity, all an_out bits are inactive, and frame_done=0.
REQ-031 Reset asserted mid-frame takes effect immediately (asynchronously); after release, scanning restarts at digit 0 with a full SCAN_DIV dwell.
REQ-032 The first output cycle after reset release selects digit 0.

Verification
REQ-033 DIGITS=4, SCAN_DIV=4, load bcd_in=16'h1234 -> an_out low-active sequence 1110,1101,1011,0111 with seg_out 0110011 (4), 1111001 (3), 1101101 (2), 0110000 (1); 4 cycles per digit; frame_done every 16 cycles.
REQ-034 blank_lz=1, load 16'h0007 -> digits 3..1 seg_out=0000000 and digit 0 shows 1110000; load 16'h0000 -> only digit 0 lit, showing 1111110.
REQ-035 BLINK_DIV=2, blink_mask=4'b0010, dp_in=4'b0010 -> digit 1 seg and dp lit for 2 frames, dark for 2 frames, repeating; other digits always lit.
REQ-036 Load 16'h5A9F -> digits 0 and 2 blank; digit 3 shows 1011011 and digit 1 shows 1111011; SEG_ACTIVE_LOW=1 yields the bitwise inverse.
REQ-037 Assert rst during digit 2 dwell -> outputs inactive within the same cycle; after release, digit 0 is selected first and the shadow register reads 0.
REQ-038 load pulsed on the same edge as a tick -> the first cycle of the new digit displays the new data, never the old.
